// File: rtl/fact_pkg.sv
// Shared widths and state encoding for the factorial job dispatcher.
package fact_pkg;

  localparam int N_W   = 4;
  localparam int RES_W = 32;
  localparam int MAX_N = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } fact_disp_state_t;

endpackage

// File: rtl/fact_req_fifo.sv
// Request FIFO: DEPTH x N_W entries, registered occupancy, head exposed
// combinationally. Pointers wrap naturally because DEPTH is a power of two.
module fact_req_fifo
  import fact_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [N_W-1:0]   i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [N_W-1:0]   o_head
);

  logic [N_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; payload needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fact_dispatch.sv
// Dispatcher in front of the fact unit: queues requests, runs them one at a
// time through go/in, captures the outcome (or a watchdog abort) and holds it
// on a valid/ready response port until taken.
module fact_dispatch
  import fact_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [N_W-1:0]   req_n,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N_W-1:0]   rsp_n,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             fact_go,
  output logic [N_W-1:0]   fact_in,
  input  logic             fact_done,
  input  logic             fact_error,
  input  logic [RES_W-1:0] fact_result,
  output logic [CNT_W-1:0] pending,
  output logic             busy
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  fact_disp_state_t r_state, w_state_nxt;
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             w_full, w_empty, w_pop;
  logic [N_W-1:0]   w_head;
  logic [15:0]      r_wdog;
  logic             w_wdog_hit;
  logic             w_cap_err, w_cap_done, w_cap_to, w_clear;
  logic [N_W-1:0]   r_n;
  logic [RES_W-1:0] r_result;
  logic             r_err, r_to;

  // Reset asserts immediately and releases two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  fact_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (w_rst_n),
    .i_push  (req_valid),
    .i_data  (req_n),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending),
    .o_head  (w_head)
  );

  assign req_ready   = w_rst_n && !w_full;
  assign fact_go     = (r_state == ST_RUN);
  assign rsp_valid   = (r_state == ST_HOLD);
  assign busy        = (r_state != ST_IDLE);
  assign fact_in     = r_n;
  assign rsp_n       = r_n;
  assign rsp_result  = r_result;
  assign rsp_error   = r_err;
  assign rsp_timeout = r_to;
  assign w_wdog_hit  = (r_wdog == WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; error outranks done, done outranks timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cap_err   = 1'b0;
    w_cap_done  = 1'b0;
    w_cap_to    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fact_error) begin
          w_cap_err   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (fact_done) begin
          w_cap_done  = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_wdog_hit) begin
          w_cap_to    = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog: cleared on job start, counts every RUN cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                r_wdog <= '0;
    else if (w_pop)              r_wdog <= '0;
    else if (r_state == ST_RUN)  r_wdog <= r_wdog + 16'd1;
  end

  // Operand and response registers; zeroed in reset so every output reads 0.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_n      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      if (w_pop) r_n <= w_head;
      if (w_cap_err) begin
        r_err    <= 1'b1;
        r_result <= '0;
      end else if (w_cap_done) begin
        r_result <= fact_result;
      end else if (w_cap_to) begin
        r_to     <= 1'b1;
        r_result <= '0;
      end else if (w_clear) begin
        r_err    <= 1'b0;
        r_to     <= 1'b0;
        r_result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fact_dispatch.sv
// Directed bench for fact_dispatch with a behavioural stand-in for fact.
module tb_fact_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_n = 4'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_n;
  logic [31:0] rsp_result;
  logic        rsp_error, rsp_timeout;
  logic        fact_go;
  logic [3:0]  fact_in;
  logic        fact_done = 1'b0;
  logic        fact_error = 1'b0;
  logic [31:0] fact_result = 32'd0;
  logic [2:0]  pending;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic m_hang = 1'b0;
  int   m_cnt = 0;

  fact_dispatch #(.DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .fact_go(fact_go), .fact_in(fact_in),
    .fact_done(fact_done), .fact_error(fact_error), .fact_result(fact_result),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fac(input logic [3:0] n);
    logic [31:0] p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  // fact stand-in: Done (and Error for n>12) after 6 cycles of go, held until go drops.
  always @(posedge clk) begin
    if (!fact_go) begin
      m_cnt <= 0; fact_done <= 1'b0; fact_error <= 1'b0; fact_result <= 32'd0;
    end else if (!m_hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 5) begin
        fact_done <= 1'b1;
        if (fact_in > 4'd12) begin
          fact_error <= 1'b1; fact_result <= 32'hDEADBEEF;
        end else fact_result <= fac(fact_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] n);
    int t = 0;
    req_valid = 1'b1; req_n = n;
    while (!req_ready && t < 100) begin tick(); t++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL push_ready n=%0d: req_ready=%0b required 1", n, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 200) begin tick(); t++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL wait_rsp: rsp_valid=%0b required 1 within 200 cycles", rsp_valid);
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({fact_go, rsp_valid, busy, req_ready, rsp_error, rsp_timeout} !== 6'b0 ||
        pending !== 3'd0 || fact_in !== 4'd0 || rsp_n !== 4'd0 || rsp_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: go=%0b vld=%0b busy=%0b rdy=%0b pend=%0d in=%0d res=%0d required all 0",
               fact_go, rsp_valid, busy, req_ready, pending, fact_in, rsp_result);
    end
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic test_single();
    push(4'd5);
    checks++;
    if (pending !== 3'd1 || fact_go !== 1'b0) begin
      errors++; $display("FAIL single_accept: pending=%0d go=%0b required 1/0", pending, fact_go);
    end
    tick();
    checks++;
    if (fact_go !== 1'b1 || pending !== 3'd0 || fact_in !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_run_entry: go=%0b pend=%0d in=%0d busy=%0b required 1/0/5/1",
               fact_go, pending, fact_in, busy);
    end
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd5 || rsp_result !== 32'd120 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: n=%0d res=%0d err=%0b to=%0b required 5/120/0/0",
               rsp_n, rsp_result, rsp_error, rsp_timeout);
    end
    accept();
    checks++;
    if (rsp_valid !== 1'b0 || fact_go !== 1'b0 || busy !== 1'b1 || rsp_result !== 32'd0) begin
      errors++;
      $display("FAIL single_release: vld=%0b go=%0b busy=%0b res=%0d required 0/0/1/0",
               rsp_valid, fact_go, busy, rsp_result);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ns [5] = '{4'd3, 4'd7, 4'd10, 4'd12, 4'd2};
    logic [31:0] rs [5] = '{32'd6, 32'd5040, 32'd3628800, 32'd479001600, 32'd2};
    for (int i = 0; i < 5; i++) push(ns[i]);
    checks++;
    if (pending !== 3'd4 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: pending=%0d ready=%0b required 4/0", pending, req_ready);
    end
    req_valid = 1'b1; req_n = 4'd9;
    tick(); tick(); tick();
    req_valid = 1'b0;
    checks++;
    if (pending !== 3'd4) begin
      errors++; $display("FAIL b2b_no_overflow: pending=%0d required 4", pending);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      checks++;
      if (rsp_n !== ns[i] || rsp_result !== rs[i] || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp%0d: n=%0d res=%0d err=%0b to=%0b required %0d/%0d/0/0",
                 i, rsp_n, rsp_result, rsp_error, rsp_timeout, ns[i], rs[i]);
      end
      accept();
      checks++;
      if (fact_go !== 1'b0) begin errors++; $display("FAIL b2b_gap_a%0d: go=%0b required 0", i, fact_go); end
      tick();
      checks++;
      if (fact_go !== 1'b0) begin errors++; $display("FAIL b2b_gap_b%0d: go=%0b required 0", i, fact_go); end
      tick();
      checks++;
      if (i < 4) begin
        if (fact_go !== 1'b1 || fact_in !== ns[i+1]) begin
          errors++;
          $display("FAIL b2b_next%0d: go=%0b in=%0d required 1/%0d", i, fact_go, fact_in, ns[i+1]);
        end
      end else if (busy !== 1'b0 || pending !== 3'd0) begin
        errors++; $display("FAIL b2b_drained: busy=%0b pend=%0d required 0/0", busy, pending);
      end
    end
  endtask

  task automatic test_error();
    push(4'd13);
    push(4'd4);
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd13 || rsp_error !== 1'b1 || rsp_result !== 32'd0 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL error_rsp: n=%0d err=%0b res=%0d to=%0b required 13/1/0/0",
               rsp_n, rsp_error, rsp_result, rsp_timeout);
    end
    accept();
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd4 || rsp_result !== 32'd24 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL error_next: n=%0d res=%0d err=%0b required 4/24/0", rsp_n, rsp_result, rsp_error);
    end
    accept();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int t = 0;
    int cnt = 0;
    m_hang = 1'b1;
    push(4'd6);
    while (!fact_go && t < 10) begin tick(); t++; end
    while (!rsp_valid && cnt < 100) begin tick(); cnt++; end
    checks++;
    if (cnt !== 20) begin
      errors++; $display("FAIL timeout_cycles: run lasted %0d cycles, required 20", cnt);
    end
    checks++;
    if (rsp_timeout !== 1'b1 || rsp_result !== 32'd0 || rsp_error !== 1'b0 || rsp_n !== 4'd6) begin
      errors++;
      $display("FAIL timeout_rsp: to=%0b res=%0d err=%0b n=%0d required 1/0/0/6",
               rsp_timeout, rsp_result, rsp_error, rsp_n);
    end
    m_hang = 1'b0;
    push(4'd9);
    accept();
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd9 || rsp_result !== 32'd362880 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next: n=%0d res=%0d to=%0b required 9/362880/0", rsp_n, rsp_result, rsp_timeout);
    end
    accept();
    tick(); tick();
  endtask

  task automatic test_hold_stall();
    int bad = 0;
    push(4'd8); push(4'd2); push(4'd3);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_n !== 4'd8 || rsp_result !== 32'd40320 ||
          fact_go !== 1'b0 || pending !== 3'd2) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles (vld=%0b n=%0d res=%0d go=%0b pend=%0d), required 0",
               bad, rsp_valid, rsp_n, rsp_result, fact_go, pending);
    end
    accept();
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd2 || rsp_result !== 32'd2) begin
      errors++; $display("FAIL hold_next1: n=%0d res=%0d required 2/2", rsp_n, rsp_result);
    end
    accept();
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd3 || rsp_result !== 32'd6) begin
      errors++; $display("FAIL hold_next2: n=%0d res=%0d required 3/6", rsp_n, rsp_result);
    end
    accept();
    tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    m_hang = 1'b1;
    push(4'd5); push(4'd6); push(4'd7); push(4'd8);
    checks++;
    if (fact_go !== 1'b1 || pending !== 3'd3) begin
      errors++; $display("FAIL midrst_setup: go=%0b pend=%0d required 1/3", fact_go, pending);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (fact_go !== 1'b0 || busy !== 1'b0 || pending !== 3'd0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b0 || fact_in !== 4'd0) begin
      errors++;
      $display("FAIL midrst_async: go=%0b busy=%0b pend=%0d vld=%0b rdy=%0b in=%0d required all 0",
               fact_go, busy, pending, rsp_valid, req_ready, fact_in);
    end
    tick(); tick();
    rst = 1'b1; m_hang = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (pending !== 3'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_after: pend=%0d rdy=%0b required 0/1", pending, req_ready);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid || fact_go) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_stale: %0d cycles with activity, required 0", seen);
    end
    push(4'd3);
    wait_rsp();
    checks++;
    if (rsp_n !== 4'd3 || rsp_result !== 32'd6) begin
      errors++; $display("FAIL midrst_recover: n=%0d res=%0d required 3/6", rsp_n, rsp_result);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_timeout();
    test_hold_stall();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/fact_dispatch.md
# fact_dispatch

Job dispatcher sitting directly upstream of the `fact` factorial unit. Accepts factorial requests over a valid/ready stream, buffers them in a small FIFO, and sequences them one at a time into `fact` via its `go`/`in` pins. Captures `result`/`Error` on `Done` and presents each outcome on a valid/ready response stream. Adds a watchdog so a hung `fact` cannot stall the queue.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255: max cycles in RUN before the job is aborted; 1..65535.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_n`  in  4  factorial operand.
- `req_ready`  out  1  FIFO not full.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_n`  out  4  operand of this response.
- `rsp_result`  out  32  n!; 0 on error or timeout.
- `rsp_error`  out  1  `fact` reported Error.
- `rsp_timeout`  out  1  watchdog expired.
- `fact_go`  out  1  drives `fact.go`.
- `fact_in`  out  4  drives `fact.in`.
- `fact_done`  in  1  from `fact.Done`.
- `fact_error`  in  1  from `fact.Error`.
- `fact_result`  in  32  from `fact.result`.
- `pending`  out  clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Push on `req_valid && req_ready`. `req_ready = (pending != DEPTH)`, from registered count only.
- FSM states: IDLE, RUN, HOLD, RELEASE.
- IDLE: if FIFO non-empty, pop head into `fact_in`/`rsp_n`, clear watchdog, go to RUN.
- RUN: `fact_go = 1`, `fact_in` stable. Watchdog increments each cycle.
  - `fact_error` sampled high: `rsp_error = 1`, `rsp_result = 0`, go to HOLD. Error wins if `fact_done` is high in the same cycle.
  - Else `fact_done` sampled high: `rsp_result = fact_result`, go to HOLD.
  - Else watchdog reaches `TIMEOUT`: `rsp_timeout = 1`, `rsp_result = 0`, go to HOLD.
- HOLD: `fact_go = 0`, `rsp_valid = 1`. All `rsp_*` are stable until `rsp_ready`, then go to RELEASE.
- RELEASE: `rsp_valid = 0`, `fact_go = 0`, `rsp_*` flags cleared. Unconditionally go to IDLE. Guarantees at least 2 low cycles of `go` between jobs so `fact` returns to its idle state.
- No operand pre-screening. n > 12 is reported through `fact_error`, passed through verbatim.
- Simultaneous push and pop in one cycle: `pending` is unchanged and the FIFO order is preserved.
- FIFO pointers wrap modulo `DEPTH`.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, FIFO empty. All outputs 0, including `fact_go`, `fact_in`, `rsp_*`, `pending`, `busy`. `req_ready` = 1 once `rst` is released.
- Reset mid-RUN: `fact_go` drops asynchronously and the in-flight job is discarded with no response.
- Request accepted at edge k into an empty FIFO: `pending` = 1 after k. Pop and RUN entry at k+1. `fact_go` high from k+1.
- Done sampled at edge d: `rsp_valid` high after d.
- Response accepted at edge a: RELEASE after a, IDLE after a+1. The next RUN is at the earliest after a+2.
- Timeout: RUN lasts exactly `TIMEOUT` cycles, then `rsp_valid` rises.
- `busy` = 1 in RUN, HOLD and RELEASE.

## Structure
- `fact_pkg`:
  - `N_W = 4`, `RES_W = 32`, `MAX_N = 12`.
  - `fact_disp_state_t` enum for IDLE, RUN, HOLD, RELEASE.
- Sub-module `fact_req_fifo`:
  - Parameterized `DEPTH` × `N_W` synchronous FIFO.
  - Ports: push, pop, full, empty, count, head data.
  - Same async active-low `rst`.
- Top-level contents: FSM, watchdog counter, response registers.

## Test plan
- Reset, push n=5, `fact` model completes after 6 cycles → `fact_go` high from 1 cycle after push, `rsp_valid` with `rsp_n`=5, `rsp_result`=120, flags 0. `fact_go` low ≥2 cycles before next job.
- Push 3, 7, 10, 12 back-to-back with DEPTH=4 → `req_ready` drops at `pending`=4. Responses arrive in order: 6, 5040, 3628800, 479001600.
- Push n=13 with the model asserting Error → `rsp_error`=1, `rsp_result`=0. The next queued job n=4 still returns 24.
- Model never asserts Done, TIMEOUT=20 → `rsp_timeout`=1 exactly 20 cycles after RUN entry, then the next job proceeds.
- Hold `rsp_ready`=0 for 10 cycles with 2 jobs queued → `rsp_*` stable, `fact_go`=0, `pending` stays 2.
- Assert `rst` low mid-RUN with 3 queued → all outputs 0 immediately. After release, `pending`=0 and no stale response appears.
